// File: rtl/mono_hit_tx_emu_if.sv
// Register bus between a host and mono_hit_tx_emu.
interface mono_hit_tx_emu_if #(
    parameter int unsigned ABUSWIDTH = 16
);
    logic [ABUSWIDTH-1:0] BUS_ADD;
    logic [7:0]           BUS_DATA_IN;
    logic [7:0]           BUS_DATA_OUT;
    logic                 BUS_WR;
    logic                 BUS_RD;

    modport master (output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, input BUS_DATA_OUT);
    modport slave  (input BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, output BUS_DATA_OUT);
endinterface

// File: rtl/mono_hit_tx_emu.sv
// MONOPIX chip-side emulator: buffers injected hits, raises TOKEN and
// answers each READ pulse with one gray-coded 30-bit word on TX_DATA/TX_CLK.
module mono_hit_tx_emu #(
    parameter int unsigned ABUSWIDTH = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                    BUS_CLK,
    input  logic                    RST,
    mono_hit_tx_emu_if.slave        bus,
    input  logic                    HIT_WR,
    input  logic [29:0]             HIT_DATA,
    input  logic                    TX_READ,
    input  logic                    TX_FREEZE,
    output logic                    TX_TOKEN,
    output logic                    TX_DATA,
    output logic                    TX_CLK
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WW = 30;
    localparam int unsigned BW = 5;
    localparam logic [7:0]  VERSION = 8'd1;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic           irst;
    logic           en_q, dis_gray_q;
    logic [7:0]     lost_cnt_q, data_out_q, rd_data;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q, vis_ptr_q, wr_ptr_nxt;
    logic [PW-1:0]  total_fill, vis_fill;
    logic [WW-1:0]  mem_q [DEPTH];
    logic           read_meta_q, read_sync_q, read_sync_dly_q;
    logic           freeze_meta_q, freeze_sync_q;
    logic [DW-1:0]  div_cnt_q;
    logic           tx_clk_q, token_q;
    logic           full, push, pop, read_rise, fall_tick;
    logic [WW-1:0]  hit_word, enc_word;
    state_t         state_q, state_d;
    logic [WW-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic           tx_data_q, tx_data_d;
    logic           unused_bits;

    // A write to address 0 acts as a soft reset of the whole block.
    assign irst = RST | (bus.BUS_WR & (bus.BUS_ADD == ABUSWIDTH'(0)));

    assign total_fill = wr_ptr_q - rd_ptr_q;
    assign vis_fill   = vis_ptr_q - rd_ptr_q;
    assign full       = (total_fill == PW'(DEPTH));
    assign push       = HIT_WR & (~full | pop);
    assign wr_ptr_nxt = wr_ptr_q + PW'(push);
    assign read_rise  = read_sync_q & ~read_sync_dly_q;
    assign fall_tick  = en_q & tx_clk_q & (div_cnt_q == DW'(CLK_DIV - 1));

    // Gray-code only the LE/TE timestamps; row/col pass through.
    assign hit_word = mem_q[rd_ptr_q[AW-1:0]];
    assign enc_word = dis_gray_q ? hit_word :
                      {hit_word[29:22] ^ {1'b0, hit_word[29:23]},
                       hit_word[21:14] ^ {1'b0, hit_word[21:15]},
                       hit_word[13:0]};

    assign unused_bits = ^bus.BUS_DATA_IN[7:2];

    // Register read mux.
    always_comb begin
        rd_data = 8'h00;
        case (bus.BUS_ADD)
            ABUSWIDTH'(0): rd_data = VERSION;
            ABUSWIDTH'(2): rd_data = {6'd0, dis_gray_q, en_q};
            ABUSWIDTH'(3): rd_data = lost_cnt_q;
            ABUSWIDTH'(4): rd_data = 8'(vis_fill);
            default:       rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= HIT_DATA;
    end

    // Control registers, buffer pointers, synchronisers and TX_CLK divider.
    always_ff @(posedge BUS_CLK) begin
        if (irst) begin
            en_q            <= 1'b0;
            dis_gray_q      <= 1'b0;
            lost_cnt_q      <= 8'h00;
            data_out_q      <= 8'h00;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            vis_ptr_q       <= '0;
            read_meta_q     <= 1'b0;
            read_sync_q     <= 1'b0;
            read_sync_dly_q <= 1'b0;
            freeze_meta_q   <= 1'b0;
            freeze_sync_q   <= 1'b0;
            div_cnt_q       <= '0;
            tx_clk_q        <= 1'b0;
            token_q         <= 1'b0;
        end else begin
            read_meta_q     <= TX_READ;
            read_sync_q     <= read_meta_q;
            read_sync_dly_q <= read_sync_q;
            freeze_meta_q   <= TX_FREEZE;
            freeze_sync_q   <= freeze_meta_q;
            if (bus.BUS_WR && (bus.BUS_ADD == ABUSWIDTH'(2))) begin
                en_q       <= bus.BUS_DATA_IN[0];
                dis_gray_q <= bus.BUS_DATA_IN[1];
            end
            if (bus.BUS_RD) data_out_q <= rd_data;
            if (HIT_WR && !push && (lost_cnt_q != 8'hFF)) lost_cnt_q <= lost_cnt_q + 8'd1;
            wr_ptr_q <= wr_ptr_nxt;
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            // While frozen, newly written words stay invisible to TOKEN and readout.
            if (!freeze_sync_q) vis_ptr_q <= wr_ptr_nxt;
            if (!en_q) begin
                div_cnt_q <= '0;
                tx_clk_q  <= 1'b0;
            end else if (div_cnt_q == DW'(CLK_DIV - 1)) begin
                div_cnt_q <= '0;
                tx_clk_q  <= ~tx_clk_q;
            end else begin
                div_cnt_q <= div_cnt_q + DW'(1);
            end
            token_q <= en_q & (vis_fill != '0);
        end
    end

    // Readout FSM state register.
    always_ff @(posedge BUS_CLK) begin
        if (irst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Readout FSM next state: pop on READ, shift out on TX_CLK falling ticks.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_rise && en_q && (vis_fill != '0)) begin
                    pop       = 1'b1;
                    shreg_d   = enc_word;
                    tx_data_d = enc_word[WW-1];
                    bit_cnt_d = BW'(WW - 1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!en_q) begin
                    tx_data_d = 1'b0;
                    state_d   = IDLE;
                end else if (fall_tick) begin
                    if (bit_cnt_q == '0) begin
                        tx_data_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        shreg_d   = {shreg_q[WW-2:0], 1'b0};
                        tx_data_d = shreg_q[WW-2];
                        bit_cnt_d = bit_cnt_q - BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.BUS_DATA_OUT = data_out_q;
    assign TX_TOKEN         = token_q;
    assign TX_DATA          = tx_data_q;
    assign TX_CLK           = tx_clk_q;

endmodule
